// File: rtl/dfe_coeff_sequencer.sv
// dfe_coeff_sequencer: loads LEN coefficient words from RAM into the DFE, waits for its done flag,
// then gates the received-sample stream into the DFE; a reload drains, resets and reloads.
module dfe_coeff_sequencer #(
  parameter int PULSE_RESPONSE_LENGTH = 5,
  parameter int SIGNAL_RESOLUTION     = 8,
  parameter int COEF_BASE             = 0,
  parameter int ADDR_W                = 8,
  parameter int DRAIN_CYCLES          = 4,
  parameter int TIMEOUT_CYCLES        = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         reload_req,
  output logic                         coef_rd_en,
  output logic [ADDR_W-1:0]            coef_rd_addr,
  input  logic [63:0]                  coef_rd_data,
  output logic                         dfe_rstn,
  output logic                         dfe_load_mem,
  output logic [7:0]                   dfe_location,
  output logic [63:0]                  dfe_mem_data,
  input  logic                         dfe_done_wait,
  input  logic [SIGNAL_RESOLUTION-1:0] s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  output logic [SIGNAL_RESOLUTION-1:0] dfe_signal_in,
  output logic                         dfe_signal_in_valid,
  output logic                         busy,
  output logic                         running,
  output logic                         timeout_err
);
  localparam int LEN = PULSE_RESPONSE_LENGTH;
  localparam int CW  = 16;
  typedef enum logic [2:0] {IDLE, DFE_RST, LOAD, WAIT_DONE, RUN, DRAIN, ERROR} state_t;
  state_t                         state_q, state_d;
  logic [CW-1:0]                  cnt_q, cnt_d;
  logic [SIGNAL_RESOLUTION-1:0]   sig_q;
  logic                           sig_vld_q;
  logic                           accept;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sig_q     <= '0;
      sig_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sig_vld_q <= accept;
      if (accept) sig_q <= s_data;
    end
  end
  // one shared counter: load index, timeout and drain; it restarts on every state change
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, ERROR: state_d = start ? DFE_RST : state_q;
      DFE_RST:     state_d = LOAD;
      LOAD:        state_d = (cnt_q == CW'(LEN + 1)) ? WAIT_DONE : LOAD;
      WAIT_DONE:   state_d = dfe_done_wait ? RUN : (cnt_q == CW'(TIMEOUT_CYCLES - 1)) ? ERROR : WAIT_DONE;
      RUN:         state_d = reload_req ? DRAIN : RUN;
      DRAIN:       state_d = (cnt_q == CW'(DRAIN_CYCLES - 1)) ? DFE_RST : DRAIN;
      default:     state_d = IDLE;
    endcase
    cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;
  end
  assign dfe_load_mem        = state_q == LOAD;
  assign coef_rd_en          = dfe_load_mem && cnt_q < CW'(LEN);
  assign coef_rd_addr        = coef_rd_en ? ADDR_W'(COEF_BASE) + ADDR_W'(cnt_q) : '0;
  assign dfe_location        = dfe_load_mem ? (coef_rd_en ? 8'(cnt_q) : 8'(LEN - 1)) : '0;
  assign dfe_mem_data        = dfe_load_mem ? coef_rd_data : '0;
  assign dfe_rstn            = !rst && state_q != DFE_RST;
  assign s_ready             = state_q == RUN && !reload_req;
  assign accept              = s_valid && s_ready;
  assign dfe_signal_in       = sig_q;
  assign dfe_signal_in_valid = sig_vld_q;
  assign busy                = !(state_q inside {IDLE, RUN, ERROR});
  assign running             = state_q == RUN;
  assign timeout_err         = state_q == ERROR;
endmodule

// File: tb/tb_dfe_coeff_sequencer.sv
// tb_dfe_coeff_sequencer: randomized scenario bench with a RAM model and a sample scoreboard
module tb_dfe_coeff_sequencer;
  localparam int LEN = 5, SR = 8, AW = 8, DRN = 4, TMO = 64;
  localparam logic [7:0] BASE = 8'h10;
  logic clk = 0, rst = 1, start = 0, reload_req = 0, dfe_done_wait = 0, s_valid = 0;
  logic [SR-1:0] s_data = '0;
  logic coef_rd_en, dfe_rstn, dfe_load_mem, s_ready, dfe_signal_in_valid, busy, running, timeout_err;
  logic [AW-1:0] coef_rd_addr;
  logic [63:0] coef_rd_data, dfe_mem_data;
  logic [7:0] dfe_location;
  logic [SR-1:0] dfe_signal_in;
  logic [63:0] ram [256];
  int n_vec = 0, n_err = 0;
  bit prev_acc = 0;
  logic [SR-1:0] prev_data = '0;
  dfe_coeff_sequencer #(.PULSE_RESPONSE_LENGTH(LEN), .SIGNAL_RESOLUTION(SR), .COEF_BASE(int'(BASE)),
    .ADDR_W(AW), .DRAIN_CYCLES(DRN), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .reload_req(reload_req), .coef_rd_en(coef_rd_en),
    .coef_rd_addr(coef_rd_addr), .coef_rd_data(coef_rd_data), .dfe_rstn(dfe_rstn),
    .dfe_load_mem(dfe_load_mem), .dfe_location(dfe_location), .dfe_mem_data(dfe_mem_data),
    .dfe_done_wait(dfe_done_wait), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .dfe_signal_in(dfe_signal_in), .dfe_signal_in_valid(dfe_signal_in_valid), .busy(busy),
    .running(running), .timeout_err(timeout_err));
  always #5 clk = ~clk;
  always @(posedge clk) if (coef_rd_en) coef_rd_data <= ram[coef_rd_addr];
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic settle;
    @(negedge clk);
  endtask
  task automatic do_start(input bit from_err);
    start = 1;
    settle;
    chk("pre_start_busy", busy, 0);
    chk("pre_start_err", timeout_err, from_err);
    cyc;
    start = 0;
    settle;
    chk("rst_pulse", dfe_rstn, 0);
    chk("rst_busy", busy, 1);
    chk("rst_err_clr", timeout_err, 0);
    chk("rst_load", dfe_load_mem, 0);
    cyc;
  endtask
  task automatic load_body(input int abort_at);
    for (int k = 0; k < LEN + 2; k++) begin
      if (k == abort_at) begin
        rst = 1;
        #1;
        chk("arst_load", dfe_load_mem, 0);
        chk("arst_rd", coef_rd_en, 0);
        chk("arst_rstn", dfe_rstn, 0);
        chk("arst_busy", busy, 0);
        chk("arst_loc", dfe_location, 0);
        chk("arst_addr", coef_rd_addr, 0);
        cyc;
        rst = 0;
        settle;
        chk("arst_idle_rstn", dfe_rstn, 1);
        chk("arst_idle_busy", busy, 0);
        cyc;
        return;
      end
      settle;
      chk("load_mem", dfe_load_mem, 1);
      chk("rd_en", coef_rd_en, k < LEN);
      if (k < LEN) chk("rd_addr", coef_rd_addr, 8'(BASE + k));
      chk("location", dfe_location, k < LEN ? k : LEN - 1);
      if (k >= 1 && k <= LEN) chk("mem_data", dfe_mem_data, ram[8'(BASE + k - 1)]);
      chk("load_ready", s_ready, 0);
      chk("load_vld", dfe_signal_in_valid, 0);
      cyc;
    end
  endtask
  task automatic wait_done(input int d);
    for (int i = 0; i < d; i++) begin
      settle;
      chk("wait_busy", busy, 1);
      chk("wait_run", running, 0);
      chk("wait_load", dfe_load_mem, 0);
      cyc;
    end
    dfe_done_wait = 1;
    settle;
    chk("done_busy", busy, 1);
    cyc;
    dfe_done_wait = 0;
    prev_acc = 0;
  endtask
  task automatic run_phase(input int n, input bit reload_last, input bit start_rand, input bit directed);
    logic [SR-1:0] dir [3];
    bit exp_rdy;
    dir[0] = 8'h7F; dir[1] = 8'h81; dir[2] = 8'h00;
    for (int t = 0; t < n; t++) begin
      s_valid    = (directed && t < 3) ? 1'b1 : ($urandom % 4 != 0);
      s_data     = (directed && t < 3) ? dir[t] : SR'($urandom);
      reload_req = reload_last && t == n - 1;
      start      = start_rand && ($urandom % 4 == 0);
      exp_rdy    = !reload_req;
      settle;
      chk("run_ready", s_ready, exp_rdy);
      chk("run_running", running, 1);
      chk("run_rstn", dfe_rstn, 1);
      chk("run_vld", dfe_signal_in_valid, prev_acc);
      if (prev_acc) chk("run_data", dfe_signal_in, prev_data);
      chk("run_load", dfe_load_mem, 0);
      prev_acc  = s_valid && exp_rdy;
      prev_data = s_data;
      cyc;
    end
    reload_req = 0;
    start = 0;
  endtask
  task automatic drain;
    for (int i = 0; i < DRN; i++) begin
      s_valid = 1;
      s_data  = SR'($urandom);
      settle;
      chk("drain_ready", s_ready, 0);
      chk("drain_busy", busy, 1);
      chk("drain_rstn", dfe_rstn, 1);
      chk("drain_vld", dfe_signal_in_valid, prev_acc);
      prev_acc = 0;
      cyc;
    end
    settle;
    chk("reload_rstn", dfe_rstn, 0);
    cyc;
  endtask
  initial begin
    for (int a = 0; a < 256; a++) ram[a] = {$urandom, $urandom};
    for (int k = 0; k < LEN; k++) ram[8'(BASE + k)] = 64'h0000_0000_0004_0003 | (64'(k) << 20);
    settle;
    chk("reset_rstn", dfe_rstn, 0);
    chk("reset_busy", busy, 0);
    chk("reset_load", dfe_load_mem, 0);
    chk("reset_ready", s_ready, 0);
    chk("reset_err", timeout_err, 0);
    cyc;
    rst = 0;
    settle;
    chk("idle_rstn", dfe_rstn, 1);
    chk("idle_running", running, 0);
    cyc;
    do_start(0);
    load_body(-1);
    wait_done(3);
    run_phase(12, 0, 1, 1);
    for (int k = 0; k < LEN; k++) ram[8'(BASE + k)] = {$urandom, $urandom};
    run_phase(8, 1, 0, 0);
    drain;
    load_body(-1);
    wait_done($urandom_range(0, 5));
    run_phase(10, 0, 0, 0);
    run_phase(5, 1, 1, 0);
    drain;
    load_body(-1);
    s_valid = 1;
    for (int i = 0; i < TMO; i++) begin
      settle;
      chk("tmo_wait_err", timeout_err, 0);
      chk("tmo_wait_busy", busy, 1);
      cyc;
    end
    settle;
    chk("tmo_err", timeout_err, 1);
    chk("tmo_busy", busy, 0);
    chk("tmo_ready", s_ready, 0);
    cyc;
    do_start(1);
    load_body(2);
    do_start(0);
    load_body(-1);
    wait_done(1);
    run_phase(20, 0, 1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
